// File: rtl/exec_unit_pipe.sv
// Handshaked execute stage: single-cycle ALU/address/compare/jump ops into a registered
// output slot, a multi-cycle MUL sequenced by a small FSM, squash via flush, sticky HALT.
module exec_unit_pipe #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned IMM_W   = 2,
    parameter int unsigned PC_W    = 8,
    parameter int unsigned JADDR_W = 6,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [DATA_W-1:0]  in_b,
    input  logic [IMM_W-1:0]   in_imm,
    input  logic [JADDR_W-1:0] in_jaddr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TAG_W-1:0]   out_tag,
    output logic [DATA_W-1:0]  out_result,
    output logic [DATA_W-1:0]  out_store_data,
    output logic [PC_W-1:0]    out_pc,
    output logic               out_is_jump,
    output logic               out_is_store,
    output logic               out_zero,
    output logic               out_carry,
    output logic               out_illegal,
    output logic               halted
);

    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_BUSY,
        ST_MUL_DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_ADDI = 4'd4,
        OP_LD   = 4'd5,
        OP_ST   = 4'd6,
        OP_CMP  = 4'd7,
        OP_JMP  = 4'd8,
        OP_HALT = 4'd9,
        OP_MUL  = 4'd10
    } op_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  mul_a_q, mul_a_d;
    logic [DATA_W-1:0]  mul_b_q, mul_b_d;
    logic [TAG_W-1:0]   mul_tag_q, mul_tag_d;

    logic               out_valid_q, out_valid_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic [DATA_W-1:0]  out_result_q, out_result_d;
    logic [DATA_W-1:0]  out_sd_q, out_sd_d;
    logic [PC_W-1:0]    out_pc_q, out_pc_d;
    logic               out_jmp_q, out_jmp_d;
    logic               out_st_q, out_st_d;
    logic               out_zero_q, out_zero_d;
    logic               out_carry_q, out_carry_d;
    logic               out_ill_q, out_ill_d;
    logic               halted_q, halted_d;

    logic               slot_free;
    logic               accept;
    logic               is_mul;
    logic               mul_load;
    logic [DATA_W-1:0]  imm_ext;
    logic [DATA_W:0]    sum_ext;
    logic [DATA_W-1:0]  mul_res;

    logic [DATA_W-1:0]  alu_res;
    logic [DATA_W-1:0]  alu_sd;
    logic [PC_W-1:0]    alu_pc;
    logic               alu_jmp;
    logic               alu_st;
    logic               alu_carry;
    logic               alu_ill;

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = rst_n && !halted_q && !flush && (state_q == ST_IDLE) && slot_free;
    assign accept    = in_valid && in_ready;
    assign is_mul    = (in_op == OP_MUL);
    assign mul_load  = (state_q == ST_MUL_DONE) && slot_free;
    assign imm_ext   = DATA_W'(in_imm);
    assign sum_ext   = {1'b0, in_a} + {1'b0, in_b};
    assign mul_res   = mul_a_q * mul_b_q;

    always_comb begin
        alu_res   = '0;
        alu_sd    = '0;
        alu_pc    = '0;
        alu_jmp   = 1'b0;
        alu_st    = 1'b0;
        alu_carry = 1'b0;
        alu_ill   = 1'b0;
        case (in_op)
            OP_ADD: begin
                alu_res   = sum_ext[DATA_W-1:0];
                alu_carry = sum_ext[DATA_W];
            end
            OP_SUB: begin
                alu_res   = in_a - in_b;
                alu_carry = (in_a < in_b);
            end
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_ADDI: alu_res = in_a + imm_ext;
            OP_LD:   alu_res = in_a + imm_ext;
            OP_ST: begin
                alu_res = in_a + imm_ext;
                alu_sd  = in_b;
                alu_st  = 1'b1;
            end
            OP_CMP:  alu_res = (in_a == in_b) ? '1 : '0;
            OP_JMP: begin
                alu_pc  = PC_W'(in_jaddr);
                alu_jmp = 1'b1;
            end
            OP_HALT: alu_res = '0;
            OP_MUL:  alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // MUL sequencing: operands are captured on accept so the input bus is free while busy
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        mul_tag_d = mul_tag_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && is_mul) begin
                        state_d   = ST_MUL_BUSY;
                        cnt_d     = CNT_W'(1);
                        mul_a_d   = in_a;
                        mul_b_d   = in_b;
                        mul_tag_d = in_tag;
                    end
                end
                ST_MUL_BUSY: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
                        state_d = ST_MUL_DONE;
                    end
                end
                ST_MUL_DONE: begin
                    if (slot_free) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_tag_d    = out_tag_q;
        out_result_d = out_result_q;
        out_sd_d     = out_sd_q;
        out_pc_d     = out_pc_q;
        out_jmp_d    = out_jmp_q;
        out_st_d     = out_st_q;
        out_zero_d   = out_zero_q;
        out_carry_d  = out_carry_q;
        out_ill_d    = out_ill_q;
        halted_d     = halted_q || (accept && (in_op == OP_HALT));
        if (flush) begin
            out_valid_d  = 1'b0;
            out_tag_d    = '0;
            out_result_d = '0;
            out_sd_d     = '0;
            out_pc_d     = '0;
            out_jmp_d    = 1'b0;
            out_st_d     = 1'b0;
            out_zero_d   = 1'b0;
            out_carry_d  = 1'b0;
            out_ill_d    = 1'b0;
        end else if (mul_load) begin
            out_valid_d  = 1'b1;
            out_tag_d    = mul_tag_q;
            out_result_d = mul_res;
            out_sd_d     = '0;
            out_pc_d     = '0;
            out_jmp_d    = 1'b0;
            out_st_d     = 1'b0;
            out_zero_d   = (mul_res == '0);
            out_carry_d  = 1'b0;
            out_ill_d    = 1'b0;
        end else if (accept && !is_mul) begin
            out_valid_d  = 1'b1;
            out_tag_d    = in_tag;
            out_result_d = alu_res;
            out_sd_d     = alu_sd;
            out_pc_d     = alu_pc;
            out_jmp_d    = alu_jmp;
            out_st_d     = alu_st;
            out_zero_d   = (alu_res == '0);
            out_carry_d  = alu_carry;
            out_ill_d    = alu_ill;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_tag_q    <= '0;
            out_valid_q  <= 1'b0;
            out_tag_q    <= '0;
            out_result_q <= '0;
            out_sd_q     <= '0;
            out_pc_q     <= '0;
            out_jmp_q    <= 1'b0;
            out_st_q     <= 1'b0;
            out_zero_q   <= 1'b0;
            out_carry_q  <= 1'b0;
            out_ill_q    <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_tag_q    <= mul_tag_d;
            out_valid_q  <= out_valid_d;
            out_tag_q    <= out_tag_d;
            out_result_q <= out_result_d;
            out_sd_q     <= out_sd_d;
            out_pc_q     <= out_pc_d;
            out_jmp_q    <= out_jmp_d;
            out_st_q     <= out_st_d;
            out_zero_q   <= out_zero_d;
            out_carry_q  <= out_carry_d;
            out_ill_q    <= out_ill_d;
            halted_q     <= halted_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_tag        = out_tag_q;
    assign out_result     = out_result_q;
    assign out_store_data = out_sd_q;
    assign out_pc         = out_pc_q;
    assign out_is_jump    = out_jmp_q;
    assign out_is_store   = out_st_q;
    assign out_zero       = out_zero_q;
    assign out_carry      = out_carry_q;
    assign out_illegal    = out_ill_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Scoreboard bench for exec_unit_pipe: directed cases plus randomized traffic with
// random backpressure and flush, checked against an arithmetic reference model.
module tb_exec_unit_pipe;
    localparam int DW = 8, TW = 3, IW = 2, PW = 8, JW = 6, ML = 3;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready;
    logic [3:0]    in_op;
    logic [TW-1:0] in_tag;
    logic [DW-1:0] in_a, in_b;
    logic [IW-1:0] in_imm;
    logic [JW-1:0] in_jaddr;
    logic          out_valid, out_ready;
    logic [TW-1:0] out_tag;
    logic [DW-1:0] out_result, out_store_data;
    logic [PW-1:0] out_pc;
    logic          out_is_jump, out_is_store, out_zero, out_carry, out_illegal, halted;

    always #5 clk = ~clk;

    exec_unit_pipe #(.DATA_W(DW), .TAG_W(TW), .IMM_W(IW), .PC_W(PW), .JADDR_W(JW), .MUL_LAT(ML)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_tag(in_tag), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
        .in_jaddr(in_jaddr), .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_result(out_result), .out_store_data(out_store_data), .out_pc(out_pc),
        .out_is_jump(out_is_jump), .out_is_store(out_is_store), .out_zero(out_zero),
        .out_carry(out_carry), .out_illegal(out_illegal), .halted(halted)
    );

    typedef struct {
        int tag, res, sd, pc, jmp, st, zero, carry, ill;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   rand_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int op, input int a, input int b, input int imm,
                                   input int ja, input int tag);
        exp_t e;
        int   r;
        e.tag = tag; e.sd = 0; e.pc = 0; e.jmp = 0; e.st = 0; e.carry = 0; e.ill = 0;
        r = 0;
        case (op)
            0:       begin r = a + b; e.carry = (r > 255) ? 1 : 0; end
            1:       begin r = a - b; e.carry = (a < b) ? 1 : 0; end
            2:       r = a & b;
            3:       r = a | b;
            4, 5:    r = a + imm;
            6:       begin r = a + imm; e.sd = b; e.st = 1; end
            7:       r = (a == b) ? 255 : 0;
            8:       begin e.pc = ja; e.jmp = 1; end
            9:       r = 0;
            10:      r = a * b;
            default: e.ill = 1;
        endcase
        r = r & 255;
        e.res = r;
        e.zero = (r == 0) ? 1 : 0;
        return e;
    endfunction

    // Monitor: compares every handshaken result and checks slot stability under backpressure
    exp_t snap;
    bit   hold = 0;
    always @(negedge clk) begin
        exp_t e;
        if (hold && out_valid === 1'b1) begin
            chk("hold_tag", 32'(out_tag), snap.tag);
            chk("hold_result", 32'(out_result), snap.res);
            chk("hold_store_data", 32'(out_store_data), snap.sd);
            chk("hold_flags", {out_is_jump, out_is_store, out_zero, out_carry, out_illegal},
                {snap.jmp[0], snap.st[0], snap.zero[0], snap.carry[0], snap.ill[0]});
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected: got out_valid=1 tag=%0d, required no output", out_tag);
            end else begin
                e = sb.pop_front();
                chk("sb_tag", 32'(out_tag), e.tag);
                chk("sb_result", 32'(out_result), e.res);
                chk("sb_store_data", 32'(out_store_data), e.sd);
                chk("sb_pc", 32'(out_pc), e.pc);
                chk("sb_flags", {out_is_jump, out_is_store, out_zero, out_carry, out_illegal},
                    {e.jmp[0], e.st[0], e.zero[0], e.carry[0], e.ill[0]});
            end
        end
        hold = (out_valid === 1'b1 && out_ready === 1'b0);
        snap.tag = out_tag; snap.res = out_result; snap.sd = out_store_data;
        snap.jmp = out_is_jump; snap.st = out_is_store; snap.zero = out_zero;
        snap.carry = out_carry; snap.ill = out_illegal;
        if (flush === 1'b1 || rst_n === 1'b0) sb.delete();
    end

    always @(posedge clk) begin
        if (rand_en) begin
            #1;
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 40) == 0;
        end
    end

    task automatic issue(input int op, input int a, input int b, input int imm, input int ja,
                         input int tag, output int waits);
        bit done = 0;
        waits = 0;
        in_valid = 1'b1; in_op = 4'(op); in_a = 8'(a); in_b = 8'(b);
        in_imm = 2'(imm); in_jaddr = 6'(ja); in_tag = 3'(tag);
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                sb.push_back(model(op, a, b, imm, ja, tag));
                done = 1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: op %0d not accepted within 200 cycles, required acceptance", op);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {out_valid, out_tag, out_result, out_store_data, out_pc, out_is_jump,
                   out_is_store, out_zero, out_carry, out_illegal, halted}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        int w, cyc, op;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_tag = '0; in_a = '0; in_b = '0; in_imm = '0; in_jaddr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_outputs");
        chk("reset_in_ready", 32'(in_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // Directed single-cycle ops, back to back
        issue(0, 'hF0, 'h20, 0, 0, 5, w);
        chk("add_waits", w, 0);
        chk("add_valid", 32'(out_valid), 1);
        chk("add_result", 32'(out_result), 'h10);
        chk("add_carry_zero_tag", {out_carry, out_zero, out_tag}, {1'b1, 1'b0, 3'd5});
        issue(1, 'h03, 'h05, 0, 0, 1, w);
        chk("sub_throughput", w, 0);
        chk("sub_result", 32'(out_result), 'hFE);
        chk("sub_borrow", 32'(out_carry), 1);
        issue(7, 'h7A, 'h7A, 0, 0, 2, w);
        chk("cmp_result", 32'(out_result), 'hFF);
        issue(6, 'h10, 'h55, 3, 0, 4, w);
        chk("st_result", 32'(out_result), 'h13);
        chk("st_data", 32'(out_store_data), 'h55);
        chk("st_flag", 32'(out_is_store), 1);

        // MUL latency
        issue(10, 'h12, 'h11, 0, 0, 3, w);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            chk("mul_busy_in_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
            cyc++;
        end
        chk("mul_latency", cyc, ML);
        chk("mul_result", 32'(out_result), 'h32);
        chk("mul_tag", 32'(out_tag), 3);

        // MUL result lands while consumer stalls: slot holds
        issue(10, 'h0F, 'h0F, 0, 0, 6, w);
        out_ready = 1'b0;
        repeat (ML + 3) begin
            @(posedge clk); #1;
        end
        chk("mul_stall_valid", 32'(out_valid), 1);
        chk("mul_stall_result", 32'(out_result), 'hE1);
        chk("mul_stall_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Backpressure on a single-cycle op, then accept on the draining cycle
        out_ready = 1'b0;
        issue(0, 'h01, 'h02, 0, 0, 1, w);
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_result", 32'(out_result), 3);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(3, 'h0C, 'h30, 0, 0, 7, w);
        chk("bp_same_cycle_accept", w, 0);
        chk("bp_next_result", 32'(out_result), 'h3C);
        @(posedge clk); #1;

        // Flush during MUL_BUSY, then flush with a valid op
        issue(10, 'h05, 'h07, 0, 0, 4, w);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 1);
        repeat (5) begin
            @(negedge clk);
            chk("flush_no_valid", 32'(out_valid), 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = 4'd0; in_a = 8'h11; in_b = 8'h22; in_tag = 3'd1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_blocks_accept", 32'(in_ready), 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_drop_valid", 32'(out_valid), 0);

        // Illegal op
        issue(13, 'h44, 'h55, 1, 9, 3, w);
        chk("illegal_flag", 32'(out_illegal), 1);
        chk("illegal_result", 32'(out_result), 0);
        chk("illegal_zero", 32'(out_zero), 1);

        // Randomized traffic
        rand_en = 1;
        for (int i = 0; i < 300; i++) begin
            op = $urandom % 15;
            if (op >= 9) op++;
            issue(op, $urandom % 256, $urandom % 256, $urandom % 4, $urandom % 64, $urandom % 8, w);
            if ($urandom % 4 == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_en = 0;
        @(posedge clk); #2;
        flush = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        // HALT is sticky through flush
        issue(9, 'h12, 'h34, 0, 0, 2, w);
        chk("halt_valid", 32'(out_valid), 1);
        chk("halt_tag", 32'(out_tag), 2);
        chk("halt_state", 32'(halted), 1);
        @(posedge clk); #1;
        chk("halt_in_ready", 32'(in_ready), 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("halt_after_flush", {halted, in_ready}, 2'b10);

        // One-cycle reset clears everything
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_all_zero("reset2_outputs");
        @(negedge clk);
        chk("reset2_in_ready", 32'(in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
